// File: rtl/butterfly_writeback.sv
// Purpose: buffers butterfly result pairs and writes each as two serial RAM words (y0 first, then y1).
// Latency: a pair accepted while idle has y0 written 2 cycles later and y1 3 cycles later (grant held high).
// Backpressure: in_ready drops when the pair FIFO is full (no same-cycle pop credit); ram_grant low stalls WR0/WR1.
module butterfly_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] y0,
  input  logic [2*DATA_WIDTH-1:0] y1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic                    ram_grant,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [2*DATA_WIDTH-1:0] ram_wdata,
  output logic                    idle
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr1;
    logic [WW-1:0]         y1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [WW-1:0]         y0;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  pair_t         mem [FIFO_DEPTH];
  pair_t         hold;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Ready is taken from the registered count only, so a full FIFO stalls even when popping.
  assign fifo_empty = (count == '0);
  assign in_ready   = (count < CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign idle       = (state == IDLE) && fifo_empty;

  // Pair storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {addr1, y1, addr0, y0};
    end
  end

  // Pointers wrap naturally since the depth is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register and the hold register that owns the pair being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        hold <= mem[rd_ptr];
      end
    end
  end

  // Next state, pop decision and RAM port drive; address/data come from registered state only.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WR0;
        end
      end
      WR0: begin
        ram_we    = ram_grant;
        ram_addr  = hold.addr0;
        ram_wdata = hold.y0;
        if (ram_grant) begin
          state_nxt = WR1;
        end
      end
      WR1: begin
        ram_we    = ram_grant;
        ram_addr  = hold.addr1;
        ram_wdata = hold.y1;
        if (ram_grant) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = WR0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_butterfly_writeback.sv
// Bench for butterfly_writeback: directed steps with a write scoreboard.
// Accepted pairs push two expected writes; every ram_we cycle pops and compares.
// Reset discards queued expectations, mirroring the design discarding its buffers.
module tb_butterfly_writeback;

  localparam int DW = 16;
  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
  } wr_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] y0;
  logic [2*DW-1:0] y1;
  logic [AW-1:0]   addr0;
  logic [AW-1:0]   addr1;
  logic            ram_grant;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [2*DW-1:0] ram_wdata;
  logic            idle;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  butterfly_writeback #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .addr0     (addr0),
    .addr1     (addr1),
    .ram_grant (ram_grant),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic [AW-1:0] a0, input logic [2*DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [2*DW-1:0] d1);
    addr0 = a0;
    y0    = d0;
    addr1 = a1;
    y1    = d1;
  endtask

  // Record expected writes for every accepted pair, y0 before y1.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back('{addr: addr0, data: y0});
      exp_q.push_back('{addr: addr1, data: y1});
    end
  end

  // Compare every RAM write against the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && ram_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL stale_write observed addr=0x%0h data=0x%0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", 64'(ram_addr), 64'(e.addr));
        check("sb_data", 64'(ram_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    int run;
    int maxrun;
    int nw;
    int nrdy0;
    int acc;
    int k;
    int push2_at;
    int block_at;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ram_grant = 1'b0;
    set_pair('0, '0, '0, '0);

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    next_cycle();
    rst_n = 1'b1;

    // Single pair: accepted cycle 0, y0 written cycle 2, y1 cycle 3, idle cycle 4.
    next_cycle();
    ram_grant = 1'b1;
    in_valid  = 1'b1;
    set_pair(10'd5, 32'h0001_0002, 10'd6, 32'h0003_0004);
    @(negedge clk);
    check("t1_c0_ready", 64'(in_ready), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_c1_idle", 64'(idle), 64'd0);
    check("t1_c1_we", 64'(ram_we), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t1_c2_we", 64'(ram_we), 64'd1);
    check("t1_c2_addr", 64'(ram_addr), 64'd5);
    check("t1_c2_data", 64'(ram_wdata), 64'h0001_0002);
    next_cycle();
    @(negedge clk);
    check("t1_c3_we", 64'(ram_we), 64'd1);
    check("t1_c3_addr", 64'(ram_addr), 64'd6);
    check("t1_c3_data", 64'(ram_wdata), 64'h0003_0004);
    next_cycle();
    @(negedge clk);
    check("t1_c4_idle", 64'(idle), 64'd1);
    check("t1_c4_we", 64'(ram_we), 64'd0);

    // Stream of 8 pairs every other cycle: 16 back-to-back writes, never stalled.
    run = 0; maxrun = 0; nw = 0; nrdy0 = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      in_valid = (i < 16) && (i % 2 == 0);
      set_pair(10'(100 + i), 32'hA000_0000 + 32'(i), 10'(200 + i), 32'hB000_0000 + 32'(i));
      @(negedge clk);
      if (!in_ready) nrdy0++;
      if (ram_we) begin
        nw++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("t2_writes", 64'(nw), 64'd16);
    check("t2_run", 64'(maxrun), 64'd16);
    check("t2_not_ready", 64'(nrdy0), 64'd0);

    // Grant stall in WR0 for 3 cycles.
    next_cycle();
    ram_grant = 1'b0;
    in_valid  = 1'b1;
    set_pair(10'h3F0, 32'hDEAD_BEEF, 10'h3F1, 32'hCAFE_F00D);
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("t3_stall_we", 64'(ram_we), 64'd0);
      check("t3_stall_addr", 64'(ram_addr), 64'h3F0);
      check("t3_stall_data", 64'(ram_wdata), 64'hDEAD_BEEF);
    end
    next_cycle();
    ram_grant = 1'b1;
    @(negedge clk);
    check("t3_y0_we", 64'(ram_we), 64'd1);
    check("t3_y0_addr", 64'(ram_addr), 64'h3F0);
    next_cycle();
    @(negedge clk);
    check("t3_y1_we", 64'(ram_we), 64'd1);
    check("t3_y1_addr", 64'(ram_addr), 64'h3F1);
    check("t3_y1_data", 64'(ram_wdata), 64'hCAFE_F00D);
    next_cycle();
    @(negedge clk);
    check("t3_idle", 64'(idle), 64'd1);

    // FIFO full: pair A goes to hold, then exactly two more fit with grant low.
    next_cycle();
    ram_grant = 1'b0;
    in_valid  = 1'b1;
    set_pair(10'd32, 32'h1000_0000, 10'd33, 32'h2000_0000);
    next_cycle();
    in_valid = 1'b0;
    acc = 0; k = 1; push2_at = -1; block_at = -1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      in_valid = 1'b1;
      set_pair(10'(32 + 2 * k), 32'h1000_0000 | 32'(k), 10'(33 + 2 * k), 32'h2000_0000 | 32'(k));
      @(negedge clk);
      if (in_ready) begin
        acc++;
        k++;
        if (acc == 2) push2_at = i;
      end else if (block_at < 0) begin
        block_at = i;
      end
    end
    check("t4_accepted", 64'(acc), 64'd2);
    check("t4_block_cycle", 64'(block_at), 64'(push2_at + 1));
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      in_valid  = 1'b0;
      ram_grant = 1'b1;
      @(negedge clk);
      if (i == 1) check("t4_no_pop_credit", 64'(in_ready), 64'd0);
      if (ram_we) nw++;
    end
    check("t4_writes", 64'(nw), 64'd6);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Async reset during WR1 with a second pair still queued.
    next_cycle();
    in_valid = 1'b1;
    set_pair(10'h050, 32'h5555_0000, 10'h051, 32'h5555_0001);
    next_cycle();
    set_pair(10'h060, 32'h6666_0000, 10'h061, 32'h6666_0001);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    check("t5_wr1_we", 64'(ram_we), 64'd1);
    check("t5_wr1_addr", 64'(ram_addr), 64'h051);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_we", 64'(ram_we), 64'd0);
    check("t5_rst_ready", 64'(in_ready), 64'd1);
    check("t5_rst_idle", 64'(idle), 64'd1);
    check("t5_rst_addr", 64'(ram_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      if (ram_we) nw++;
    end
    check("t5_no_stale", 64'(nw), 64'd0);

    // Normal operation after reset.
    next_cycle();
    in_valid = 1'b1;
    set_pair(10'h2AA, 32'h7777_8888, 10'h155, 32'h9999_AAAA);
    next_cycle();
    in_valid = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    check("end_drained", 64'(exp_q.size()), 64'd0);
    check("end_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_writeback.md
# butterfly_writeback

Write-back serializer on the output side of the shared radix-2 butterfly. It takes one result pair (y0, y1) per handshake, each with its own target address. It buffers pairs in a small FIFO and issues them to the single-port working RAM as two consecutive word writes. It is the mirror of the read-side feeder, which turns two serial RAM reads into one butterfly input pair.

## Interface
- DATA_WIDTH, 16, width of one real or imaginary component; a RAM word is 2*DATA_WIDTH (imag in upper half, real in lower half).
- ADDR_WIDTH, 10, RAM address width.
- FIFO_DEPTH, 2, pair FIFO depth; power of two, ≥2.

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a result pair is presented.
- in_ready  out  1  FIFO can accept a pair this cycle.
- y0  in  2*DATA_WIDTH  first butterfly output.
- y1  in  2*DATA_WIDTH  second butterfly output.
- addr0  in  ADDR_WIDTH  destination of y0.
- addr1  in  ADDR_WIDTH  destination of y1.
- ram_grant  in  1  RAM write port granted to this block this cycle.
- ram_we  out  1  write strobe.
- ram_addr  out  ADDR_WIDTH  write address.
- ram_wdata  out  2*DATA_WIDTH  write data.
- idle  out  1  FSM in IDLE and FIFO empty.

## Operation
- Pair FIFO stores {addr1, y1, addr0, y0} per entry. Circular read and write pointers wrap at FIFO_DEPTH. An occupancy counter spans 0..FIFO_DEPTH.
- Push when in_valid && in_ready.
- in_ready = (count < FIFO_DEPTH). It depends on registered count only. It gives no credit for a pop in the same cycle, so a full FIFO stalls the producer for one cycle even if it is popping.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- The FSM holds one popped pair in a hold register.
- States and transitions:
  - IDLE:
    - FIFO non-empty: pop into hold, go to WR0.
    - Otherwise stay.
  - WR0:
    - Drive ram_addr = hold.addr0, ram_wdata = hold.y0, ram_we = ram_grant.
    - ram_grant=1: go to WR1.
    - Otherwise stay; outputs held stable.
  - WR1:
    - Drive ram_addr = hold.addr1, ram_wdata = hold.y1, ram_we = ram_grant.
    - ram_grant=1 and FIFO non-empty: pop into hold, go to WR0 (no IDLE bubble).
    - ram_grant=1 and FIFO empty: go to IDLE.
    - ram_grant=0: stay.
- In IDLE: ram_we=0, ram_addr=0, ram_wdata=0.
- ram_we is combinational from registered state AND ram_grant. ram_addr and ram_wdata depend on registered state only.
- y0 is always written before y1, and pairs are written in acceptance order.
- addr0 == addr1 is not checked. Both writes are issued, so y1 wins.
- No arithmetic is performed: data and addresses pass through bit-exact.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, FIFO empty, pointers=0, hold=0.
  - Outputs: in_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, idle=1.
- Release of rst_n is synchronous to clk externally. The first push is legal on the first edge with rst_n high.
- Reset asserted mid-operation: any pending FIFO entries and the held pair are discarded, and outputs reach reset values immediately.
- Latency, from a pair accepted at the edge ending cycle t:
  - FSM in IDLE: y0 is written in cycle t+2 and y1 in cycle t+3, with grant held high.
  - FSM in WR1 with grant: the next pair follows directly.
- Throughput: one pair per 2 cycles sustained with continuous grant. This matches the feeder's one pair per 2 cycles, so FIFO_DEPTH=2 never stalls in steady state.
- Each cycle with ram_grant=0 in WR0/WR1 adds one cycle.
- idle falls in the cycle after the first push.

## Test plan
- Single pair after reset, grant=1: y0=0x0001_0002 @addr0=5, y1=0x0003_0004 @addr1=6 accepted in cycle 0.
  - Required: ram_we=1 with addr 5 / 0x00010002 in cycle 2, addr 6 / 0x00030004 in cycle 3.
  - Required: idle=1 again in cycle 4.
- Back-to-back stream: 8 pairs, in_valid every other cycle, grant=1.
  - Required: 16 consecutive write cycles, in order, in_ready never 0.
- Grant stall: grant=0 for 3 cycles during WR0.
  - Required: ram_we=0, addr/data stable; the y0 write occurs on the first grant=1 cycle and y1 on the next.
- FIFO full: grant=0, in_valid held high.
  - Required: exactly 2 pairs accepted, in_ready=0 from the cycle after the second push.
  - Required: after grant=1, all three held pairs (hold + 2 FIFO) are written in order.
- Async reset mid-write: rst_n low during WR1.
  - Required: ram_we=0, in_ready=1, idle=1 within the same cycle.
  - Required: no stale writes after release.
